// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO sequencer: ALU control codes, FSM state
// encoding and the latched long-operation kind.
package hilo_muldiv_ctrl_pkg;

  // ALU control codes, shared with the ALU control decoder
  localparam logic [4:0] ALU_MULT = 5'b00101;
  localparam logic [4:0] ALU_DIV  = 5'b01011;
  localparam logic [4:0] ALU_MADD = 5'b01100;
  localparam logic [4:0] ALU_MSUB = 5'b01101;
  localparam logic [4:0] ALU_MFHI = 5'b10000;
  localparam logic [4:0] ALU_MTHI = 5'b10001;
  localparam logic [4:0] ALU_MFLO = 5'b10010;
  localparam logic [4:0] ALU_MTLO = 5'b10011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_MULT = 2'd0,
    OP_MADD = 2'd1,
    OP_MSUB = 2'd2,
    OP_DIV  = 2'd3
  } op_t;

  // True for every code this block reacts to; everything else belongs to the ALU
  function automatic logic is_hilo_code(input logic [4:0] code);
    case (code)
      ALU_MULT, ALU_DIV, ALU_MADD, ALU_MSUB,
      ALU_MFHI, ALU_MTHI, ALU_MFLO, ALU_MTLO: is_hilo_code = 1'b1;
      default:                                is_hilo_code = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared iterative datapath: a 2*WIDTH register acting as the shift-add
// accumulator for multiply ({partial, multiplier}) and as the restoring
// divider's {remainder, quotient} pair. Operands are unsigned magnitudes.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,    // start: acc = {0, op_a}, hold op_b
  input  logic               step,    // advance one bit
  input  logic               is_div,  // step as divide instead of multiply
  input  logic [WIDTH-1:0]   op_a,    // multiplier / dividend
  input  logic [WIDTH-1:0]   op_b,    // multiplicand / divisor
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_nxt;

  // One step: multiply adds then shifts right, divide shifts left and tries a subtract
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb_q : '0)};
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    acc_nxt   = acc;
    if (is_div) begin
      if (!div_trial[WIDTH])
        acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Operand and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      opb_q <= '0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, op_a};
      opb_q <= op_b;
    end else if (step) begin
      acc   <= acc_nxt;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register pair and multiply/divide sequencer beside the EX-stage ALU.
// Handshake: an issued HI/LO code is taken in a cycle where issue=1 and
// busy=0; while busy=1 such a code raises stall (combinational) and the
// pipeline must hold and re-present issue/alu_ctl/a/b until stall drops.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic [4:0]       alu_ctl,
  input  logic             unsigned_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hilo_out,
  output logic             hilo_out_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output state_t           dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t             state, state_nxt;
  op_t                op;
  logic [CW-1:0]      cnt;
  logic               neg_res, neg_rem;
  logic               accept, is_signed, a_neg, b_neg;
  logic               start_mul, start_div, dbz;
  logic [WIDTH-1:0]   mag_a, mag_b, rem, quo;
  logic [2*WIDTH-1:0] acc, prod, fin_val;

  // Decode, accept/stall and operand magnitudes; madd/msub are always signed
  always_comb begin
    busy      = (state != ST_IDLE);
    accept    = issue & is_hilo_code(alu_ctl) & ~busy;
    stall     = issue & is_hilo_code(alu_ctl) & busy;
    is_signed = (alu_ctl == ALU_MADD) | (alu_ctl == ALU_MSUB) | ~unsigned_op;
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    mag_a     = a_neg ? -a : a;
    mag_b     = b_neg ? -b : b;
    start_mul = accept & ((alu_ctl == ALU_MULT) | (alu_ctl == ALU_MADD) |
                          (alu_ctl == ALU_MSUB));
    start_div = accept & (alu_ctl == ALU_DIV) & (b != '0);
    dbz       = accept & (alu_ctl == ALU_DIV) & (b == '0);
    hilo_out_valid = accept & ((alu_ctl == ALU_MFHI) | (alu_ctl == ALU_MFLO));
    hilo_out  = '0;
    if (accept && alu_ctl == ALU_MFHI) hilo_out = hi;
    if (accept && alu_ctl == ALU_MFLO) hilo_out = lo;
  end

  assign dbg_state = state;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start_mul | start_div),
    .step   ((state == ST_MUL) | (state == ST_DIV)),
    .is_div (state == ST_DIV),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .acc    (acc)
  );

  assign rem = acc[2*WIDTH-1:WIDTH];
  assign quo = acc[WIDTH-1:0];

  // Sign fixup and write-back value used in FIN
  always_comb begin
    prod    = neg_res ? -acc : acc;
    fin_val = prod;
    case (op)
      OP_MADD: fin_val = {hi, lo} + prod;
      OP_MSUB: fin_val = {hi, lo} - prod;
      OP_DIV:  fin_val = {(neg_rem ? -rem : rem), (neg_res ? -quo : quo)};
      default: fin_val = prod;
    endcase
  end

  // FSM next state: WIDTH iteration cycles, then one FIN cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_mul)      state_nxt = ST_MUL;
        else if (start_div) state_nxt = ST_DIV;
      end
      ST_MUL, ST_DIV: if (cnt == CNT_LAST) state_nxt = ST_FIN;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Iteration counter and latched operation kind/result signs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op      <= OP_MULT;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (start_mul || start_div) begin
      cnt     <= '0;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      if (alu_ctl == ALU_MADD)      op <= OP_MADD;
      else if (alu_ctl == ALU_MSUB) op <= OP_MSUB;
      else if (alu_ctl == ALU_DIV)  op <= OP_DIV;
      else                          op <= OP_MULT;
    end else if (state == ST_MUL || state == ST_DIV) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_ONE;
    end
  end

  // Architectural HI/LO and the divide-by-zero pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      div_by_zero <= dbz;
      if (state == ST_FIN)                        {hi, lo} <= fin_val;
      else if (accept && alu_ctl == ALU_MTHI)     hi <= a;
      else if (accept && alu_ctl == ALU_MTLO)     lo <= a;
    end
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Sequencer for the HI/LO register pair and the shared iterative multiply/divide datapath. It sits beside the main ALU in EX and is driven by the same 5-bit ALU control code: mult/multu, div/divu, madd, msub, mfhi, mthi, mflo, mtlo. Long operations run for WIDTH+1 cycles. Any HI/LO access issued while an operation is in flight is held off through a Stall handshake to the pipeline.

## Interface
- WIDTH, 32, operand and HI/LO width.
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- Issue  in  1  EX-stage instruction valid this cycle.
- ALUCtl  in  5  control code: 00101 mult, 01011 div, 01100 madd, 01101 msub, 10000 mfhi, 10001 mthi, 10010 mflo, 10011 mtlo; other codes ignored.
- Unsigned  in  1  selects multu/divu for codes 00101/01011; ignored otherwise.
- A  in  WIDTH  rs operand (multiplicand/dividend; mthi/mtlo data).
- B  in  WIDTH  rt operand (multiplier/divisor).
- Stall  out  1  combinational; hold EX and re-present Issue/ALUCtl/A/B.
- Busy  out  1  long operation in flight.
- HiLoOut  out  WIDTH  mfhi/mflo result, combinational.
- HiLoOutValid  out  1  HiLoOut is valid this cycle.
- Hi, Lo  out  WIDTH  architectural HI/LO registers.
- DivByZero  out  1  one-cycle registered pulse.

## Operation
- Reset: state IDLE, Hi=Lo=0, Busy=0, DivByZero=0, iteration counter 0.
- HI/LO code accepted when Issue=1 and Busy=0.
- A HI/LO code with Issue=1 and Busy=1 gives Stall=1.
- Non-HI/LO codes: Stall=0, no effect.
- IDLE, mthi/mtlo: Hi or Lo takes A at the edge; no Busy.
- IDLE, mfhi/mflo: HiLoOut = Hi or Lo, HiLoOutValid=1, same cycle.
- IDLE, mult/madd/msub: latch |A|, |B| and result sign → MUL. Signed unless Unsigned=1; madd/msub always signed.
- IDLE, div with B=0: no state change, Hi/Lo unchanged, DivByZero=1 next cycle.
- IDLE, div with B≠0: latch magnitudes and signs → DIV.
- MUL: shift-add, one bit per cycle, WIDTH cycles → FIN.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles → FIN.
- FIN: apply signs, then write and → IDLE.
  - mult: {Hi,Lo} = product.
  - madd/msub: {Hi,Lo} = {Hi,Lo} ± product, modulo 2^(2·WIDTH).
  - div: Lo = quotient, truncated toward zero; Hi = remainder, sign of dividend.
- Signed div of most-negative / −1: Lo=0x80000000, Hi=0.
- Reset_n low at any time, including mid-MUL/DIV: immediate abort to the reset values.

## Timing
- Cycle 0: long op issued in IDLE.
- Cycles 1..WIDTH+1: Busy=1 (WIDTH iteration cycles plus FIN).
- Hi/Lo hold the new value from cycle WIDTH+2; Busy=0 in cycle WIDTH+2.
- Stalled access issued during Busy is accepted in cycle WIDTH+2 and sees the new Hi/Lo. No bypass from FIN.
- Hi/Lo outputs stay stable (old values) while Busy=1.
- Back-to-back long ops: the second is stalled until cycle WIDTH+2, then accepted; its Busy begins cycle WIDTH+3.
- mthi/mtlo: Hi/Lo update at the edge ending the issue cycle; an mfhi/mflo in the next cycle reads the new value.

## Structure
- Shared header/package:
  - ALUCtl code constants, shared with the ALU control decoder.
  - State encoding: IDLE, MUL, DIV, FIN.
- Sub-module muldiv_iter: 2·WIDTH accumulator/remainder shift datapath with per-cycle step control.
- hilo_muldiv_ctrl owns the FSM, counter, sign fixup, HI/LO registers and Stall logic.

## Test plan
- Reset: release Reset_n → Hi=0, Lo=0, Busy=0, Stall=0. Issue mfhi → HiLoOut=0, HiLoOutValid=1 same cycle.
- Signed mult, A=0xFFFFFFFD (−3), B=7:
  - Busy high exactly 33 cycles.
  - Cycle 34: Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- multu 0xFFFFFFFF × 0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001.
- Signed div −7 / 2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- Div by zero (B=0): DivByZero pulse 1 cycle, Busy stays 0, Hi/Lo unchanged.
- mult 6×7, then mflo issued at cycle 1:
  - Stall=1 cycles 1..33, HiLoOutValid=0 throughout.
  - Cycle 34: HiLoOut=42, HiLoOutValid=1.
- mthi 0, mtlo 0xFFFFFFFF, madd 1×1 → Hi=1, Lo=0. Then msub 1×1 → Hi=0, Lo=0xFFFFFFFF.
- Reset_n pulsed low at cycle 10 of a mult → Busy=0, Hi=Lo=0 immediately. No write-back after release.
